// File: rtl/pixel_dispatch_pkg.sv
// Shared definitions for the pixel dispatcher: default sizing and the
// dispatch FSM state type.
package pixel_dispatch_pkg;

  localparam int MAX_CORES = 4;
  localparam int COORD_W   = 11;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DONE
  } state_t;

endpackage

// File: rtl/pixel_dispatcher_if.sv
// Job handshake between the dispatcher (master) and up to four compute cores
// (slave). The coordinates are shared, and a per-core valid/ready pair selects the target core.
interface pixel_dispatcher_if
  import pixel_dispatch_pkg::*;
#(
  parameter int COORD_W = pixel_dispatch_pkg::COORD_W
);

  logic               job_valid_1;
  logic               job_valid_2;
  logic               job_valid_3;
  logic               job_valid_4;
  logic               compute_ready_1;
  logic               compute_ready_2;
  logic               compute_ready_3;
  logic               compute_ready_4;
  logic [COORD_W-1:0] job_x;
  logic [COORD_W-1:0] job_y;

  modport master (
    output job_valid_1, job_valid_2, job_valid_3, job_valid_4,
    output job_x, job_y,
    input  compute_ready_1, compute_ready_2, compute_ready_3, compute_ready_4
  );

  modport slave (
    input  job_valid_1, job_valid_2, job_valid_3, job_valid_4,
    input  job_x, job_y,
    output compute_ready_1, compute_ready_2, compute_ready_3, compute_ready_4
  );

endinterface

// File: rtl/raster_counter.sv
// Raster-order x/y pixel counter. It captures the frame size on load, and on
// each step it advances along the row and then to the next row.
module raster_counter
  import pixel_dispatch_pkg::*;
#(
  parameter int W = pixel_dispatch_pkg::COORD_W
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] width_in,
  input  logic [W-1:0] height_in,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         last
);

  logic [W-1:0] width_q;
  logic [W-1:0] height_q;
  logic         row_end;

  assign row_end = (x == width_q - W'(1));
  assign last    = row_end && (y == height_q - W'(1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      width_q  <= '0;
      height_q <= '0;
      x        <= '0;
      y        <= '0;
    end else if (load) begin
      width_q  <= width_in;
      height_q <= height_in;
      x        <= '0;
      y        <= '0;
    end else if (step) begin
      if (row_end) begin
        x <= '0;
        // The last pixel returns the counter to the origin so that the coordinates rest at 0.
        y <= last ? '0 : y + W'(1);
      end else begin
        x <= x + W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Frame pixel dispatcher. It hands (x,y) jobs out in raster order to the compute
// cores, using a strict round-robin over the active cores.
module pixel_dispatcher #(
  parameter int MAX_CORES = pixel_dispatch_pkg::MAX_CORES,
  parameter int COORD_W   = pixel_dispatch_pkg::COORD_W
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic [COORD_W-1:0]     screen_width,
  input  logic [COORD_W-1:0]     screen_height,
  input  logic [2:0]             no_of_extra_cores,
  pixel_dispatcher_if.master     jobs,
  output logic                   busy,
  output logic                   frame_done,
  output logic [2*COORD_W-1:0]   jobs_issued
);

  import pixel_dispatch_pkg::*;

  localparam logic [2:0] LAST_CORE = 3'(MAX_CORES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         cur;
  logic [1:0]         cores_m1;
  logic [3:0]         ready_vec;
  logic [3:0]         valid_vec;
  logic               load;
  logic               accept;
  logic               last;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  assign ready_vec = {jobs.compute_ready_4, jobs.compute_ready_3,
                      jobs.compute_ready_2, jobs.compute_ready_1};

  assign load   = (state == IDLE) && start;
  // Only the core at the round-robin index can take the job, which keeps the
  // order aligned with the downstream collector.
  assign accept = (state == DISPATCH) && ready_vec[cur];

  raster_counter #(.W(COORD_W)) u_raster (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (load),
    .step      (accept),
    .width_in  (screen_width),
    .height_in (screen_height),
    .x         (x),
    .y         (y),
    .last      (last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: next-state gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = (|screen_width && |screen_height) ? DISPATCH : DONE;
      DISPATCH: if (accept && last) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cur         <= '0;
      cores_m1    <= '0;
      jobs_issued <= '0;
    end else if (load) begin
      cores_m1    <= (no_of_extra_cores > LAST_CORE) ? LAST_CORE[1:0] : no_of_extra_cores[1:0];
      cur         <= '0;
      jobs_issued <= '0;
    end else if (accept) begin
      jobs_issued <= jobs_issued + 1'b1;
      cur         <= (cur == cores_m1) ? 2'd0 : cur + 2'd1;
    end
  end

  assign valid_vec = (state == DISPATCH) ? (4'b0001 << cur) : 4'b0000;

  assign jobs.job_valid_1 = valid_vec[0];
  assign jobs.job_valid_2 = valid_vec[1];
  assign jobs.job_valid_3 = valid_vec[2];
  assign jobs.job_valid_4 = valid_vec[3];
  assign jobs.job_x       = x;
  assign jobs.job_y       = y;

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Randomised and directed bench for pixel_dispatcher. It uses a job-order reference model
// and a scoreboard monitor that compares every offered job and every frame_done.
module tb_pixel_dispatcher;

  import pixel_dispatch_pkg::*;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 start = 1'b0;
  logic [COORD_W-1:0]   screen_width = '0;
  logic [COORD_W-1:0]   screen_height = '0;
  logic [2:0]           no_of_extra_cores = '0;
  logic                 busy;
  logic                 frame_done;
  logic [2*COORD_W-1:0] jobs_issued;

  pixel_dispatcher_if #(.COORD_W(COORD_W)) jobs_if ();

  pixel_dispatcher #(.MAX_CORES(MAX_CORES), .COORD_W(COORD_W)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .start             (start),
    .screen_width      (screen_width),
    .screen_height     (screen_height),
    .no_of_extra_cores (no_of_extra_cores),
    .jobs              (jobs_if),
    .busy              (busy),
    .frame_done        (frame_done),
    .jobs_issued       (jobs_issued)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int core;
    int x;
    int y;
  } job_t;

  job_t exp_jobs[$];
  int   exp_done[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] valid_vec();
    return {jobs_if.job_valid_4, jobs_if.job_valid_3, jobs_if.job_valid_2, jobs_if.job_valid_1};
  endfunction

  function automatic logic [3:0] ready_vec();
    return {jobs_if.compute_ready_4, jobs_if.compute_ready_3,
            jobs_if.compute_ready_2, jobs_if.compute_ready_1};
  endfunction

  // Scoreboard monitor: an offered job must equal the head of the expected
  // queue, and it is popped only when the selected core is ready.
  always @(negedge aclk) begin : monitor
    logic [3:0] v;
    int         d;
    if (aresetn) begin
      v = valid_vec();
      if (v != 4'b0000) begin
        if (exp_jobs.size() == 0) begin
          check("unexpected_job_valid", longint'(v), 0);
        end else begin
          check("job_core_onehot", longint'(v), longint'(1) << exp_jobs[0].core);
          check("job_x", longint'(jobs_if.job_x), exp_jobs[0].x);
          check("job_y", longint'(jobs_if.job_y), exp_jobs[0].y);
          if ((v & ready_vec()) != 4'b0000) void'(exp_jobs.pop_front());
        end
      end
      if (frame_done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_frame_done", longint'(frame_done), 0);
        end else begin
          d = exp_done.pop_front();
          check("jobs_issued_at_done", longint'(jobs_issued), d);
          check("busy_at_done", longint'(busy), 1);
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, longint'(valid_vec()), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_frame_done"}, longint'(frame_done), 0);
    check({tag, "_job_x"}, longint'(jobs_if.job_x), 0);
    check({tag, "_job_y"}, longint'(jobs_if.job_y), 0);
    check({tag, "_jobs_issued"}, longint'(jobs_issued), 0);
  endtask

  // mode 0: all ready; 1: random ready; 2: core 2 stalls during cycles 2..6
  task automatic drive_ready(input int mode, input int cyc);
    logic [3:0] r;
    case (mode)
      1:       for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 3) != 0);
      2:       r = (cyc >= 2 && cyc <= 6) ? 4'b1101 : 4'b1111;
      default: r = 4'b1111;
    endcase
    jobs_if.compute_ready_1 = r[0];
    jobs_if.compute_ready_2 = r[1];
    jobs_if.compute_ready_3 = r[2];
    jobs_if.compute_ready_4 = r[3];
  endtask

  // Runs one frame. If reset_after > 0, reset is asserted right after that many
  // acceptances. If exp_cycles > 0, it is the required cycle count from start
  // to the frame_done sample.
  task automatic run_frame(input int w, input int h, input int n, input int mode,
                           input int reset_after, input int exp_cycles);
    int n_eff;
    int cycles;
    int accepted;
    n_eff    = (n > MAX_CORES - 1) ? MAX_CORES - 1 : n;
    cycles   = 0;
    accepted = 0;
    for (int i = 0; i < w * h; i++) exp_jobs.push_back('{i % (n_eff + 1), i % w, i / w});
    if (reset_after == 0) exp_done.push_back(w * h);

    @(posedge aclk); #1;
    screen_width      = COORD_W'(w);
    screen_height     = COORD_W'(h);
    no_of_extra_cores = 3'(n);
    start             = 1'b1;
    drive_ready(mode, 1);
    @(posedge aclk); #1;
    start             = 1'b0;
    screen_width      = COORD_W'($urandom_range(0, 9));
    screen_height     = COORD_W'($urandom_range(0, 9));
    no_of_extra_cores = 3'($urandom_range(0, 7));

    forever begin
      @(negedge aclk);
      cycles++;
      if (cycles == 1) begin
        check("busy_after_start", longint'(busy), 1);
        check("first_job_latency", longint'(valid_vec() != 4'b0000), longint'(w * h > 0));
      end
      if (frame_done) begin
        if (exp_cycles > 0) check("frame_cycles", cycles, exp_cycles);
        break;
      end
      if ((valid_vec() & ready_vec()) != 4'b0000) accepted++;
      if (reset_after > 0 && accepted == reset_after) begin
        @(posedge aclk); #1;
        aresetn = 1'b0;
        #1;
        check_quiet("mid_frame_reset");
        exp_jobs.delete();
        repeat (3) begin
          @(negedge aclk);
          check("no_done_in_reset", longint'(frame_done), 0);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("no_done_after_reset", longint'(frame_done), 0);
        check("idle_after_reset", longint'(busy), 0);
        return;
      end
      if (cycles > 4 * w * h + 50) begin
        check("frame_timeout", 0, 1);
        exp_jobs.delete();
        exp_done.delete();
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        return;
      end
      @(posedge aclk); #1;
      drive_ready(mode, cycles + 1);
    end

    @(negedge aclk);
    check("idle_after_done", longint'(busy), 0);
    check("done_single_pulse", longint'(frame_done), 0);
    check("queue_drained", exp_jobs.size(), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    drive_ready(0, 0);
    repeat (2) @(negedge aclk);
    check_quiet("in_reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check_quiet("after_reset");

    run_frame(4, 2, 3, 0, 0, 9);   // full-rate round-robin over 4 cores
    run_frame(3, 1, 0, 0, 0, 4);   // single core takes every job
    run_frame(4, 2, 3, 2, 0, 14);  // core 2 stalls; order is held
    run_frame(0, 5, 2, 0, 0, 1);   // empty frame: straight to done
    run_frame(5, 2, 7, 0, 0, 11);  // core count clamps to 4
    run_frame(6, 3, 3, 0, 5, 0);   // reset after the 5th acceptance
    run_frame(3, 2, 1, 0, 0, 7);   // fresh frame after reset

    // start pulse while busy must be ignored
    exp_jobs.push_back('{0, 0, 0});
    exp_jobs.push_back('{1, 1, 0});
    exp_done.push_back(2);
    @(posedge aclk); #1;
    screen_width = 2; screen_height = 1; no_of_extra_cores = 1; start = 1'b1;
    drive_ready(2, 1);
    @(posedge aclk); #1;
    screen_width = 5; screen_height = 5; no_of_extra_cores = 3;
    drive_ready(2, 2);
    @(posedge aclk); #1;
    start = 1'b0;
    repeat (12) begin
      @(posedge aclk); #1;
      drive_ready(0, 0);
    end
    @(negedge aclk);
    check("ignored_start_busy", longint'(busy), 0);

    for (int f = 0; f < 12; f++)
      run_frame($urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 7), 1, 0, 0);

    repeat (3) @(negedge aclk);
    check("final_jobs_queue_empty", exp_jobs.size(), 0);
    check("final_done_queue_empty", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pixel_dispatcher.md
PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

Interface
REQ-001 The block SHALL have parameter MAX_CORES, default 4, giving the number of compute-core ports.
REQ-002 The block SHALL have parameter COORD_W, default 11, giving the pixel-coordinate width.
REQ-003 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle frame-start request.
REQ-006 The block SHALL have port screen_width, input, COORD_W bits: pixels per row.
REQ-007 The block SHALL have port screen_height, input, COORD_W bits: rows per frame.
REQ-008 The block SHALL have port no_of_extra_cores, input, 3 bits: active cores minus one.
REQ-009 The block SHALL have ports compute_ready_1..4, input, 1 bit each: core k can accept a pixel job.
REQ-010 The block SHALL have ports job_valid_1..4, output, 1 bit each: a job is offered to core k.
REQ-011 The block SHALL have ports job_x and job_y, output, COORD_W bits each: coordinates of the offered job, shared by all cores.
REQ-012 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last job is accepted.
REQ-014 The block SHALL have port jobs_issued, output, 2*COORD_W bits: count of jobs accepted in the current or last frame.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, DISPATCH and DONE.
REQ-016 In IDLE, when start=1, the block SHALL:
- latch screen_width, screen_height and no_of_extra_cores;
- clamp the latched core count to MAX_CORES-1;
- clear x, y, core index and jobs_issued.
REQ-017 From IDLE with start=1, the next state SHALL be DISPATCH if width and height are both nonzero, otherwise DONE.
REQ-018 In DISPATCH, the block SHALL assert only job_valid_(cur+1), with job_x=x and job_y=y; all other job_valid outputs are 0.
REQ-019 A job SHALL be accepted in the cycle where job_valid_k=1 and compute_ready_k=1.
REQ-020 job_valid, job_x and job_y SHALL remain stable until the job is accepted.
REQ-021 On acceptance, jobs_issued SHALL increment by 1.
REQ-022 On acceptance, cur SHALL advance by 1, wrapping to 0 after the latched core count, giving strict round-robin order 1,2,..,n+1,1.
REQ-023 On acceptance, x SHALL increment; at x=width-1, x SHALL wrap to 0 and y SHALL increment (raster order).
REQ-024 Acceptance at x=width-1 and y=height-1 SHALL move the FSM to DONE.
REQ-025 A core that is not at the cur index SHALL never receive a job, even if its ready is high (ordering must match the collecting pixel_buffer).
REQ-026 DONE SHALL assert frame_done for exactly one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in DISPATCH and DONE, and 0 in IDLE.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 Input changes to width, height or core count during a frame SHALL have no effect until the next start.
REQ-030 The first job_valid SHALL assert in the cycle after start is sampled (latency 1).
REQ-031 Back-to-back acceptances SHALL sustain 1 job per cycle when the selected core is ready.

Reset
REQ-032 On aresetn=0, the block SHALL immediately enter IDLE and clear cur, x, y and jobs_issued.
REQ-033 During and after reset, all job_valid outputs, busy and frame_done SHALL be 0, and job_x and job_y SHALL be 0.
REQ-034 Reset mid-frame SHALL abandon the frame, and no frame_done SHALL be generated for it.

Structure
REQ-035 A shared package pixel_dispatch_pkg SHALL hold MAX_CORES, COORD_W and the state enum typedef.
REQ-036 The x/y raster counter with its last-pixel flag SHALL be one sub-module, raster_counter; core selection and the FSM stay in the top level.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Width=4, height=2, no_of_extra_cores=3, all ready: 8 jobs in consecutive cycles to cores 1,2,3,4,1,2,3,4, coordinates (0,0)..(3,1); frame_done one cycle after the 8th; jobs_issued=8.
- Width=3, height=1, no_of_extra_cores=0: all 3 jobs on core 1 only; job_valid_2..4 never asserted.
- Core 2 holds ready=0 for 5 cycles while cores 1,3,4 are ready: job (1,0) stays on core 2, stable; cores 3 and 4 receive nothing until core 2 accepts.
- Width=0, height=5, start: no job_valid; busy 1 for 1 cycle; frame_done pulses; jobs_issued=0.
- no_of_extra_cores=7: behaves as 3, rotating over 4 cores.
- aresetn low after the 5th acceptance: all outputs 0 at once, no frame_done; a new start restarts at (0,0) on core 1.
